btb_assoc: RTL
==============

# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage. A fetch-PC lookup returns hit, taken prediction, 2-bit counter state and predicted target one cycle later. Resolved branches from execute update the entry: the counter saturates toward the outcome, taken branches write the target, and taken misses allocate a way by true LRU. It replaces the direct-mapped predictor/target pair.

## Interface
- num_sets, 64, sets; power of two, >= 2
- num_ways, 2, ways per set; power of two, >= 1
- idx_offset, 2, PC bits below the index (word-aligned PCs)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- rd_en  in  1  lookup request
- rd_pc  in  32  fetch PC to look up
- rd_hit  out  1  registered; valid tag match for last accepted lookup
- rd_taken  out  1  registered; rd_hit & counter[1]
- rd_ctr  out  2  registered; matching way's counter (00 on miss)
- rd_target  out  32  registered; matching way's target (0 on miss)
- upd_valid  in  1  resolved-branch update strobe
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual target (used only when upd_taken)
- flush  in  1  invalidate all entries

## Operation
- Index = pc[idx_offset+log2(num_sets)-1 : idx_offset]; tag = pc[31 : idx_offset+log2(num_sets)].
- Entry: valid, tag, ctr[1:0], target[31:0]. Per set: one age field of log2(num_ways) bits per way (0 = MRU).
- Lookup (rd_en=1): all ways of set compared; result registered. rd_en=0: outputs hold previous values.
- Update hit: ctr +1 if taken, -1 if not, saturating at 11/00; target overwritten only when upd_taken; way becomes MRU.
- Update miss, taken: victim = lowest-index invalid way, else way with max age; write valid=1, tag, ctr=10 (weakly taken), target; victim becomes MRU.
- Update miss, not taken: no state change (no allocation, no LRU change).
- LRU touch: touched way -> age 0; ways with age lower than touched way's old age -> +1; others unchanged. Lookups never touch LRU.
- flush: clears all valid bits; ages, counters and targets untouched. flush with upd_valid in same cycle: flush wins, update dropped.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

## Timing
- Reset (asynchronous): all outputs 0, all valid 0, all ctr 01, ages of set s way w = w, targets 0. Takes effect immediately, mid-lookup or mid-update; in-flight results discarded.
- Lookup latency: exactly 1 cycle; one lookup and one update accepted per cycle, no stalls.
- Same-cycle lookup and update of the same set: lookup returns pre-update contents (no bypass); lookup on the following cycle sees the update.
- Same-cycle lookup and flush: lookup returns pre-flush contents.
- Update completes in the cycle it is presented; no backpressure.

## Structure
- Package btb_pkg: ctr_t enum (four states above), ctr reset constant 01, allocate constant 10, saturating inc/dec functions, entry struct typedef parametrised by tag width via localparam computation in module.
- Sub-module btb_assoc_lru: one instance per set; inputs touch, touch_way, valid vector; outputs victim way; holds the age fields.
- Storage in flops (flush needs single-cycle invalidate of all sets).

## Test plan
Defaults: num_sets=64, num_ways=2, idx_offset=2 (index pc[7:2], tag pc[31:8]).
- Reset, lookup 0x0000_1000 -> next cycle rd_hit=0, rd_taken=0, rd_ctr=00, rd_target=0.
- Update 0x1000 taken target 0x2000, then lookup 0x1000 -> rd_hit=1, rd_taken=1, rd_ctr=10, rd_target=0x2000.
- Three not-taken updates on 0x1000 -> ctr 01, 00, 00; lookup rd_hit=1, rd_taken=0; four taken updates -> 01,10,11,11.
- Taken updates A=0x1000, B=0x1100 (same set 0), update A again, taken update C=0x1200 -> B evicted; lookups A hit, B miss, C hit target as written.
- Same-cycle lookup and taken update of new PC 0x1300 -> rd_hit=0; lookup next cycle -> rd_hit=1. Flush, then lookup A -> rd_hit=0.
- Assert rst between cycle edges after populated entries -> outputs 0 without a clock edge; after release all lookups miss.

Source files
------------

// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_pkg
// Description : Shared types and counter helpers for the branch target buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t c_ctr_reset = CTR_WNT;
  localparam ctr_t c_ctr_alloc = CTR_WT;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    return taken ? ctr_inc(c) : ctr_dec(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_assoc_lru.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc_lru
// Description : True-LRU age tracker for one set; picks the allocation victim.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_assoc_lru #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_touch,
  input  logic [WAY_W-1:0]    i_touch_way,
  input  logic [NUM_WAYS-1:0] i_valid,
  output logic [WAY_W-1:0]    o_victim
);

  localparam logic [WAY_W-1:0] c_age_max = WAY_W'(NUM_WAYS - 1);

  logic [WAY_W-1:0] r_age [NUM_WAYS];
  logic [WAY_W-1:0] w_touch_age;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_old_way;
  logic             w_found_inv;

  assign w_touch_age = r_age[i_touch_way];

  // Ages always form a permutation, so exactly one way carries the max age.
  always_comb begin
    w_found_inv = 1'b0;
    w_inv_way   = '0;
    w_old_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!i_valid[w] && !w_found_inv) begin
        w_found_inv = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
      if (r_age[w] == c_age_max) begin
        w_old_way = WAY_W'(w);
      end
    end
  end

  assign o_victim = w_found_inv ? w_inv_way : w_old_way;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_age[w] <= WAY_W'(w);
      end
    end else if (i_touch) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == i_touch_way) begin
          r_age[w] <= '0;
        end else if (r_age[w] < w_touch_age) begin
          r_age[w] <= r_age[w] + WAY_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc
// Description : Set-associative branch target buffer with 2-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_assoc
  import btb_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 2,
  parameter int IDX_OFFSET = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd_en,
  input  logic [31:0] i_rd_pc,
  output logic        o_rd_hit,
  output logic        o_rd_taken,
  output logic [1:0]  o_rd_ctr,
  output logic [31:0] o_rd_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_flush
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - IDX_OFFSET - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    ctr_t             ctr;
    logic [31:0]      target;
  } entry_t;

  entry_t r_mem [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_hit;
  entry_t           w_rd_entry;

  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [WAY_W-1:0] w_up_hit_way;
  logic [WAY_W-1:0] w_up_way;
  logic             w_up_touch;
  logic [WAY_W-1:0] w_victim [NUM_SETS];
  logic             w_unused;

  assign w_rd_idx = i_rd_pc[IDX_OFFSET +: IDX_W];
  assign w_rd_tag = i_rd_pc[31 -: TAG_W];
  assign w_up_idx = i_upd_pc[IDX_OFFSET +: IDX_W];
  assign w_up_tag = i_upd_pc[31 -: TAG_W];
  assign w_unused = ^{i_rd_pc[IDX_OFFSET-1:0], i_upd_pc[IDX_OFFSET-1:0]};

  always_comb begin
    w_rd_hit   = 1'b0;
    w_rd_entry = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_mem[w_rd_idx][w].valid && (r_mem[w_rd_idx][w].tag == w_rd_tag)) begin
        w_rd_hit   = 1'b1;
        w_rd_entry = r_mem[w_rd_idx][w];
      end
    end
  end

  always_comb begin
    w_up_hit     = 1'b0;
    w_up_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_mem[w_up_idx][w].valid && (r_mem[w_up_idx][w].tag == w_up_tag)) begin
        w_up_hit     = 1'b1;
        w_up_hit_way = WAY_W'(w);
      end
    end
  end

  // Not-taken misses leave the set untouched, including its LRU order.
  assign w_up_way   = w_up_hit ? w_up_hit_way : w_victim[w_up_idx];
  assign w_up_touch = i_upd_valid && !i_flush && (w_up_hit || i_upd_taken);

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic [NUM_WAYS-1:0] w_valid;
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      assign w_valid[w] = r_mem[s][w].valid;
    end
    btb_assoc_lru #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
    ) u_lru (
      .clk         (clk),
      .rst         (rst),
      .i_touch     (w_up_touch && (w_up_idx == IDX_W'(s))),
      .i_touch_way (w_up_way),
      .i_valid     (w_valid),
      .o_victim    (w_victim[s])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_mem[s][w] <= '{valid: 1'b0, tag: '0, ctr: c_ctr_reset, target: '0};
        end
      end
    end else if (i_flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_mem[s][w].valid <= 1'b0;
        end
      end
    end else if (i_upd_valid) begin
      if (w_up_hit) begin
        r_mem[w_up_idx][w_up_way].ctr <= ctr_step(r_mem[w_up_idx][w_up_way].ctr, i_upd_taken);
        if (i_upd_taken) begin
          r_mem[w_up_idx][w_up_way].target <= i_upd_target;
        end
      end else if (i_upd_taken) begin
        r_mem[w_up_idx][w_up_way] <= '{valid: 1'b1, tag: w_up_tag,
                                       ctr: c_ctr_alloc, target: i_upd_target};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_hit    <= 1'b0;
      o_rd_taken  <= 1'b0;
      o_rd_ctr    <= 2'b00;
      o_rd_target <= '0;
    end else if (i_rd_en) begin
      o_rd_hit    <= w_rd_hit;
      o_rd_taken  <= w_rd_hit & w_rd_entry.ctr[1];
      o_rd_ctr    <= w_rd_entry.ctr;
      o_rd_target <= w_rd_entry.target;
    end
  end

endmodule
`default_nettype wire
